cache_mem_responder: RTL and testbench

Main-memory responder serving the memory side of the direct-mapped cache.
- Accepts single-word write-through requests and whole-block line-fill read requests over a valid/ready request channel.
- Returns an ack for writes, or a burst of block words for reads, after a fixed programmable latency.
- Used as the backing store behind the cache in simulation and on the iceBlinkPico build.

---
 rtl/cache_mem_responder.sv | 275 +++++++++++++++++++++++++++
 tb/tb_cache_mem_responder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Main-memory responder behind the direct-mapped cache.
// A valid/ready request channel accepts either a single-word write or a
// whole-block read. After a fixed latency, a write returns a one-cycle
// write_ack. A read returns the aligned block as a burst of beats with
// resp_valid/resp_ready flow control.
// The backing store is never cleared; only control state is reset.

module cache_mem_responder #(
  parameter int MEM_WORDS  = 1024,
  parameter int BLOCK_SIZE = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_last,
  input  logic                  resp_ready,
  output logic                  write_ack
);

  localparam int BYTES_PER_WORD  = DATA_WIDTH / 8;
  localparam int WORDS_PER_BLOCK = BLOCK_SIZE / BYTES_PER_WORD;
  localparam int BYTE_OFF        = $clog2(BYTES_PER_WORD);
  localparam int IDX_W           = $clog2(MEM_WORDS);
  localparam int OFF_W           = $clog2(WORDS_PER_BLOCK);
  localparam int BEAT_W          = (OFF_W > 0) ? OFF_W : 1;
  localparam int CNT_W           = $clog2(LATENCY + 1);

  // WAIT lasts LATENCY-1 cycles, so the counter is loaded with LATENCY-2.
  // With LATENCY=1 the WAIT state is skipped entirely.
  localparam logic [CNT_W-1:0]  CNT_LOAD  = (LATENCY > 1) ? CNT_W'(LATENCY - 2) : {CNT_W{1'b0}};
  localparam logic [IDX_W-1:0]  OFF_MASK  = IDX_W'(WORDS_PER_BLOCK - 1);
  localparam logic [IDX_W-1:0]  BLK_MASK  = ~OFF_MASK;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_BLOCK - 1);
  localparam logic              ONE_BEAT  = (WORDS_PER_BLOCK == 1) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t                state_r,      state_s;
  logic [CNT_W-1:0]      cnt_r,        cnt_s;
  logic [BEAT_W-1:0]     beat_r,       beat_s;
  logic                  write_r,      write_s;
  logic [IDX_W-1:0]      idx_r,        idx_s;
  logic [DATA_WIDTH-1:0] wdata_r,      wdata_s;
  logic                  req_ready_r,  req_ready_s;
  logic                  resp_valid_r, resp_valid_s;
  logic [DATA_WIDTH-1:0] resp_data_r,  resp_data_s;
  logic                  resp_last_r,  resp_last_s;
  logic                  write_ack_r,  write_ack_s;

  logic [DATA_WIDTH-1:0] mem_r [MEM_WORDS];

  logic                  mem_we_s;
  logic [IDX_W-1:0]      mem_widx_s;
  logic [DATA_WIDTH-1:0] mem_wdata_s;

  logic [IDX_W-1:0]      req_idx_s;
  logic [IDX_W-1:0]      req_base_s;
  logic [BEAT_W-1:0]     beat_nxt_s;
  logic [IDX_W-1:0]      beat_idx_s;
  logic                  accept_s;
  logic                  unused_addr_s;

  // Byte-offset and high address bits are dropped, so addresses wrap silently.
  assign req_idx_s     = req_addr[BYTE_OFF +: IDX_W];
  assign req_base_s    = req_idx_s & BLK_MASK;
  assign accept_s      = req_valid && req_ready_r;
  assign unused_addr_s = ^req_addr;

  // The beat counter only walks the low offset bits, which keeps each burst inside its aligned block.
  assign beat_nxt_s = beat_r + BEAT_W'(1);
  assign beat_idx_s = idx_r | (IDX_W'(beat_nxt_s) & OFF_MASK);

  // Next-state and next-output logic for the request/response FSM.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    beat_s       = beat_r;
    write_s      = write_r;
    idx_s        = idx_r;
    wdata_s      = wdata_r;
    req_ready_s  = req_ready_r;
    resp_valid_s = resp_valid_r;
    resp_data_s  = resp_data_r;
    resp_last_s  = resp_last_r;
    write_ack_s  = 1'b0;
    mem_we_s     = 1'b0;
    mem_widx_s   = idx_r;
    mem_wdata_s  = wdata_r;

    case (state_r)
      IDLE: begin
        req_ready_s  = 1'b1;
        resp_valid_s = 1'b0;
        resp_last_s  = 1'b0;
        resp_data_s  = {DATA_WIDTH{1'b0}};
        if (accept_s) begin
          write_s     = req_write;
          idx_s       = req_write ? req_idx_s : req_base_s;
          wdata_s     = req_wdata;
          cnt_s       = CNT_LOAD;
          beat_s      = {BEAT_W{1'b0}};
          req_ready_s = 1'b0;
          if (LATENCY == 1) begin
            // Single-cycle latency: commit the write or present beat 0 straight from the accept edge.
            if (req_write) begin
              mem_we_s    = 1'b1;
              mem_widx_s  = req_idx_s;
              mem_wdata_s = req_wdata;
              write_ack_s = 1'b1;
              state_s     = ACK;
            end else begin
              resp_valid_s = 1'b1;
              resp_data_s  = mem_r[req_base_s];
              resp_last_s  = ONE_BEAT;
              state_s      = BURST;
            end
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end

      WAIT: begin
        req_ready_s = 1'b0;
        if (cnt_r == {CNT_W{1'b0}}) begin
          if (write_r) begin
            mem_we_s    = 1'b1;
            write_ack_s = 1'b1;
            state_s     = ACK;
          end else begin
            resp_valid_s = 1'b1;
            resp_data_s  = mem_r[idx_r];
            resp_last_s  = ONE_BEAT;
            state_s      = BURST;
          end
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end

      ACK: begin
        write_ack_s = 1'b0;
        req_ready_s = 1'b1;
        state_s     = IDLE;
      end

      BURST: begin
        req_ready_s = 1'b0;
        if (resp_valid_r && resp_ready) begin
          if (resp_last_r) begin
            resp_valid_s = 1'b0;
            resp_last_s  = 1'b0;
            resp_data_s  = {DATA_WIDTH{1'b0}};
            req_ready_s  = 1'b1;
            state_s      = IDLE;
          end else begin
            beat_s      = beat_nxt_s;
            resp_data_s = mem_r[beat_idx_s];
            resp_last_s = (beat_nxt_s == LAST_BEAT) ? 1'b1 : 1'b0;
          end
        end else begin
          state_s = BURST;
        end
      end

      default: begin
        state_s      = IDLE;
        req_ready_s  = 1'b1;
        resp_valid_s = 1'b0;
        resp_last_s  = 1'b0;
        resp_data_s  = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      cnt_r        <= {CNT_W{1'b0}};
      beat_r       <= {BEAT_W{1'b0}};
      write_r      <= 1'b0;
      idx_r        <= {IDX_W{1'b0}};
      wdata_r      <= {DATA_WIDTH{1'b0}};
      req_ready_r  <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_data_r  <= {DATA_WIDTH{1'b0}};
      resp_last_r  <= 1'b0;
      write_ack_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      beat_r       <= beat_s;
      write_r      <= write_s;
      idx_r        <= idx_s;
      wdata_r      <= wdata_s;
      req_ready_r  <= req_ready_s;
      resp_valid_r <= resp_valid_s;
      resp_data_r  <= resp_data_s;
      resp_last_r  <= resp_last_s;
      write_ack_r  <= write_ack_s;
    end
  end

  // Backing store write port; a reset edge suppresses any pending write.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) begin
      mem_r[mem_widx_s] <= mem_wdata_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_last  = resp_last_r;
  assign write_ack  = write_ack_r;

  cache_mem_responder_checker #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .req_ready  (req_ready_r),
    .resp_valid (resp_valid_r),
    .resp_data  (resp_data_r),
    .resp_last  (resp_last_r),
    .resp_ready (resp_ready),
    .write_ack  (write_ack_r)
  );

endmodule

// Protocol properties of the responder's outputs.
module cache_mem_responder_checker #(
  parameter int DATA_WIDTH = 32
) (
  input logic                  clk,
  input logic                  rst,
  input logic                  req_ready,
  input logic                  resp_valid,
  input logic [DATA_WIDTH-1:0] resp_data,
  input logic                  resp_last,
  input logic                  resp_ready,
  input logic                  write_ack
);

  a_ack_excl_resp: assert property (@(posedge clk) disable iff (rst)
    !(write_ack && resp_valid));

  a_ready_idle_only: assert property (@(posedge clk) disable iff (rst)
    !(req_ready && (resp_valid || write_ack)));

  a_ack_one_cycle: assert property (@(posedge clk) disable iff (rst)
    write_ack |=> !write_ack);

  a_beat_held: assert property (@(posedge clk) disable iff (rst)
    (resp_valid && !resp_ready) |=> (resp_valid && $stable(resp_data) && $stable(resp_last)));

endmodule

// File: tb/tb_cache_mem_responder.sv
// Scoreboard bench for cache_mem_responder. Expected beats are queued when a
// read is issued and are popped as the DUT hands them over. A second instance
// with LATENCY=1 covers the minimum-latency case.

module tb_cache_mem_responder;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_write, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready, resp_valid, resp_last, write_ack;
  logic [31:0] resp_data;

  logic        f_req_valid, f_req_write, f_resp_ready;
  logic [31:0] f_req_addr, f_req_wdata;
  logic        f_req_ready, f_resp_valid, f_resp_last, f_write_ack;
  logic [31:0] f_resp_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [1024];

  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } beat_t;
  beat_t exp_q[$];

  // 100 MHz clock.
  always #5 clk = ~clk;

  cache_mem_responder #(.MEM_WORDS(1024), .BLOCK_SIZE(16), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_last(resp_last), .resp_ready(resp_ready), .write_ack(write_ack));

  cache_mem_responder #(.MEM_WORDS(1024), .BLOCK_SIZE(16), .ADDR_WIDTH(32), .DATA_WIDTH(32), .LATENCY(1)) dut_fast (
    .clk(clk), .rst(rst), .req_valid(f_req_valid), .req_ready(f_req_ready), .req_write(f_req_write),
    .req_addr(f_req_addr), .req_wdata(f_req_wdata), .resp_valid(f_resp_valid), .resp_data(f_resp_data),
    .resp_last(f_resp_last), .resp_ready(f_resp_ready), .write_ack(f_write_ack));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h0000_03FF);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for req_ready, then crosses the accept edge.
  task automatic wait_accept(output int waited);
    waited = 0;
    while (!req_ready && waited < 40) begin
      step();
      waited++;
    end
    check_eq("accept_ready", 32'(req_ready), 32'd1);
    step();
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, output int waited);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = a;
    req_wdata = d;
    wait_accept(waited);
    req_valid = 1'b0;
    req_write = 1'b0;
    model[widx(a)] = d;
    for (int k = 1; k <= LAT; k++) begin
      check_eq("wr_ack", 32'(write_ack), (k == LAT) ? 32'd1 : 32'd0);
      check_eq("wr_busy", 32'(req_ready), 32'd0);
      check_eq("wr_no_resp", 32'(resp_valid), 32'd0);
      step();
    end
    check_eq("wr_ack_drop", 32'(write_ack), 32'd0);
    check_eq("wr_ready_back", 32'(req_ready), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] a, input int stall_beat, input int stall_n,
                         input int rst_beat, input bit hold_next);
    int    w;
    int    base;
    int    beat;
    int    stall_left;
    int    budget;
    bit    did_rst;
    beat_t e;
    base = widx(a) & ~3;
    for (int i = 0; i < 4; i++) begin
      e.last = (i == 3);
      e.data = model[base + i];
      exp_q.push_back(e);
    end
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_addr   = a;
    resp_ready = 1'b1;
    wait_accept(w);
    if (hold_next) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h0000_0200;
      req_wdata = 32'hC0FF_EE01;
    end else begin
      req_valid = 1'b0;
    end
    for (int k = 1; k < LAT; k++) begin
      check_eq("rd_latency_idle", 32'(resp_valid), 32'd0);
      check_eq("rd_busy", 32'(req_ready), 32'd0);
      step();
    end
    beat = 0;
    stall_left = stall_n;
    budget = 0;
    did_rst = 1'b0;
    while (exp_q.size() > 0 && budget < 60) begin
      budget++;
      if (beat == stall_beat && stall_left > 0) begin
        resp_ready = 1'b0;
        stall_left--;
      end else begin
        resp_ready = 1'b1;
      end
      check_eq("rd_valid", 32'(resp_valid), 32'd1);
      check_eq("rd_busy", 32'(req_ready), 32'd0);
      check_eq("rd_no_ack", 32'(write_ack), 32'd0);
      check_eq("rd_data", resp_data, exp_q[0].data);
      check_eq("rd_last", 32'(resp_last), 32'(exp_q[0].last));
      if (resp_ready) begin
        e = exp_q.pop_front();
        beat++;
      end
      step();
      if (rst_beat >= 0 && beat == rst_beat + 1) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_resp_last", 32'(resp_last), 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("rst_write_ack", 32'(write_ack), 32'd0);
        exp_q.delete();
        did_rst = 1'b1;
      end
    end
    check_eq("rd_beats_left", 32'(exp_q.size()), 32'd0);
    if (!did_rst) begin
      check_eq("rd_end_valid", 32'(resp_valid), 32'd0);
      check_eq("rd_end_last", 32'(resp_last), 32'd0);
      check_eq("rd_end_ready", 32'(req_ready), 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int          w;
    logic [31:0] blk [4];
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
    f_req_valid = 1'b0; f_req_write = 1'b0; f_req_addr = 32'd0; f_req_wdata = 32'd0; f_resp_ready = 1'b0;
    step();
    step();
    check_eq("rst_req_ready", 32'(req_ready), 32'd1);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_data", resp_data, 32'd0);
    check_eq("rst_resp_last", 32'(resp_last), 32'd0);
    check_eq("rst_write_ack", 32'(write_ack), 32'd0);
    check_eq("rst_fast_ready", 32'(f_req_ready), 32'd1);
    check_eq("rst_fast_valid", 32'(f_resp_valid), 32'd0);
    rst = 1'b0;
    step();

    // Preload every block the bench reads back.
    blk[0] = 32'h0000_0000; blk[1] = 32'h0000_0040; blk[2] = 32'h0000_0080; blk[3] = 32'h0000_0200;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 4; i++) begin
        do_write(blk[b] + 32'(4 * i), 32'h5000_0000 + blk[b] + 32'(i), w);
      end
    end

    // Write then read back the containing block.
    do_write(32'h0000_0040, 32'hDEAD_BEEF, w);
    do_read(32'h0000_0048, -1, 0, -1, 1'b0);

    // Stall at beat 2 for three cycles.
    for (int i = 0; i < 4; i++) begin
      do_write(32'h0000_0040 + 32'(4 * i), 32'(i + 1), w);
    end
    do_read(32'h0000_0044, 2, 3, -1, 1'b0);

    // Second request held during a burst is taken right after the last handshake.
    do_read(32'h0000_0040, -1, 0, -1, 1'b1);
    do_write(32'h0000_0200, 32'hC0FF_EE01, w);
    check_eq("held_req_wait", 32'(w), 32'd0);
    do_read(32'h0000_0200, 1, 2, -1, 1'b0);

    // Reset mid-burst after beat 1.
    do_read(32'h0000_0040, -1, 0, 1, 1'b0);
    step();

    // Reset during the WAIT of a write discards it.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0080; req_wdata = 32'hBAD0_BAD0;
    wait_accept(w);
    req_valid = 1'b0; req_write = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("wait_rst_ready", 32'(req_ready), 32'd1);
    for (int k = 0; k < 6; k++) begin
      check_eq("wait_rst_no_ack", 32'(write_ack), 32'd0);
      step();
    end
    do_read(32'h0000_0080, -1, 0, -1, 1'b0);

    // Address wrap: 0x1000 aliases word 0.
    do_write(32'h0000_1000, 32'hA5A5_A5A5, w);
    do_read(32'h0000_0000, 0, 1, -1, 1'b0);

    // LATENCY=1 instance: ack at T+1, read accepted at T+3 gives beat 0 at T+4.
    f_req_valid = 1'b1; f_req_write = 1'b1; f_req_addr = 32'h0000_0010; f_req_wdata = 32'h1357_2468;
    check_eq("fast_ready", 32'(f_req_ready), 32'd1);
    step();
    f_req_valid = 1'b0; f_req_write = 1'b0;
    check_eq("fast_ack", 32'(f_write_ack), 32'd1);
    check_eq("fast_busy", 32'(f_req_ready), 32'd0);
    step();
    check_eq("fast_ack_drop", 32'(f_write_ack), 32'd0);
    check_eq("fast_ready_back", 32'(f_req_ready), 32'd1);
    step();
    f_req_valid = 1'b1; f_req_write = 1'b0; f_req_addr = 32'h0000_0010; f_resp_ready = 1'b1;
    step();
    f_req_valid = 1'b0;
    check_eq("fast_rd_valid", 32'(f_resp_valid), 32'd1);
    check_eq("fast_rd_data", f_resp_data, 32'h1357_2468);
    for (int i = 0; i < 4; i++) begin
      check_eq("fast_beat_valid", 32'(f_resp_valid), 32'd1);
      check_eq("fast_beat_last", 32'(f_resp_last), (i == 3) ? 32'd1 : 32'd0);
      step();
    end
    check_eq("fast_end_valid", 32'(f_resp_valid), 32'd0);
    check_eq("fast_end_ready", 32'(f_req_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
